// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment capture path.
package seg7_pkg;

    // Active-low patterns, bit 6 = g ... bit 0 = a
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_F     = 7'b0001110;

    // Display encoder table: index is the nibble shown
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam int unsigned NUM_DIGITS = 6;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StResolve
    } state_e;

    typedef struct packed {
        logic [3:0] nibble;
        logic       is_blank;
        logic       is_f;
        logic       invalid;
    } digit_t;

endpackage

// File: rtl/seg7_capture_if.sv
// Segment stream in, decoded frame results out.
interface seg7_capture_if;
    logic [6:0] seg_in;
    logic       seg_valid;
    logic       seg_first;
    logic [9:0] value;
    logic [9:0] original;
    logic       complement;
    logic       frame_valid;
    logic       frame_err;
    logic       ambig;

    modport master (
        output seg_in, seg_valid, seg_first,
        input  value, original, complement, frame_valid, frame_err, ambig
    );

    modport slave (
        input  seg_in, seg_valid, seg_first,
        output value, original, complement, frame_valid, frame_err, ambig
    );
endinterface

// File: rtl/seg7_decode.sv
// Inverse of the display encoder: pattern -> nibble, with blank/invalid flags.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] nibble_o,
    output logic       is_blank_o,
    output logic       invalid_o
);

    // Table search; anything neither hex nor blank is invalid
    always_comb begin
        nibble_o   = 4'h0;
        is_blank_o = (seg_i == SEG_BLANK);
        invalid_o  = ~is_blank_o;
        for (int i = 0; i < 16; i++) begin
            if (seg_i == SEG_HEX[i]) begin
                nibble_o  = 4'(i);
                invalid_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg7_capture.sv
// Collects six display digits, resolves the frame mode and recovers the value.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int unsigned FRAME_TIMEOUT = 255
) (
    input  logic          CLOCK_50,
    input  logic          RESET,
    seg7_capture_if.slave bus
);

    localparam int unsigned TW = $clog2(FRAME_TIMEOUT + 1);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [TW-1:0] idle_q, idle_d;
    digit_t     digits_q [NUM_DIGITS];
    digit_t     digits_d [NUM_DIGITS];
    logic [9:0] value_q, value_d, original_q, original_d;
    logic       complement_q, complement_d, ambig_q, ambig_d;
    logic       frame_valid_q, frame_valid_d, frame_err_q, frame_err_d;

    logic [3:0] dec_nibble;
    logic       dec_blank, dec_invalid;
    digit_t     new_digit;

    seg7_decode u_decode (
        .seg_i      (bus.seg_in),
        .nibble_o   (dec_nibble),
        .is_blank_o (dec_blank),
        .invalid_o  (dec_invalid)
    );

    assign new_digit = '{nibble: dec_nibble, is_blank: dec_blank,
                         is_f: (bus.seg_in == SEG_F), invalid: dec_invalid};

    logic       res_err, res_comp, res_ambig;
    logic [3:0] d2_nib;
    logic [9:0] res_value;

    // Evaluate the stored frame; only consumed while in StResolve
    always_comb begin
        res_err   = 1'b0;
        res_comp  = digits_q[3].is_f;
        res_ambig = 1'b0;
        d2_nib    = digits_q[2].nibble;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digits_q[i].invalid) res_err = 1'b1;
        end
        if (!digits_q[3].is_blank && !digits_q[3].is_f) res_err = 1'b1;
        if (digits_q[4] != digits_q[3] || digits_q[5] != digits_q[3]) res_err = 1'b1;
        if (res_comp) begin
            // The display never emits a literal 0 in complement mode
            for (int i = 0; i < 3; i++) begin
                if (digits_q[i].is_blank || digits_q[i].nibble == 4'h0) res_err = 1'b1;
            end
            if (digits_q[2].is_f) d2_nib = 4'h0;
            else if (digits_q[2].nibble > 4'h3) res_err = 1'b1;
            res_ambig = digits_q[0].is_f | digits_q[1].is_f;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (digits_q[i].is_blank) res_err = 1'b1;
            end
            if (digits_q[2].nibble > 4'h3) res_err = 1'b1;
        end
        res_value = {d2_nib[1:0], digits_q[1].nibble, digits_q[0].nibble};
    end

    // Next-state: frame collection, timeout and result publication
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idle_d        = idle_q;
        digits_d      = digits_q;
        value_d       = value_q;
        original_d    = original_q;
        complement_d  = complement_q;
        ambig_d       = ambig_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;

        case (state_q)
            StCollect: begin
                if (bus.seg_valid) begin
                    idle_d = '0;
                    if (bus.seg_first) begin
                        // Silent restart: the partial frame is dropped
                        digits_d[0] = new_digit;
                        cnt_d       = 3'd1;
                    end else begin
                        digits_d[cnt_q] = new_digit;
                        cnt_d           = cnt_q + 3'd1;
                        if (cnt_q == 3'(NUM_DIGITS - 1)) state_d = StResolve;
                    end
                end else begin
                    idle_d = idle_q + 1'b1;
                    if (idle_q == TW'(FRAME_TIMEOUT - 1)) begin
                        frame_err_d = 1'b1;
                        state_d     = StIdle;
                        cnt_d       = '0;
                    end
                end
            end
            StResolve: begin
                state_d = StIdle;
                cnt_d   = '0;
                if (res_err) begin
                    frame_err_d = 1'b1;
                end else begin
                    frame_valid_d = 1'b1;
                    value_d       = res_value;
                    original_d    = res_comp ? (~res_value + 10'd1) : res_value;
                    complement_d  = res_comp;
                    ambig_d       = res_ambig;
                end
            end
            default: ;
        endcase

        // A frame start is honoured in StIdle and in the resolve cycle alike
        if (state_q != StCollect && bus.seg_valid && bus.seg_first) begin
            digits_d[0] = new_digit;
            cnt_d       = 3'd1;
            idle_d      = '0;
            state_d     = StCollect;
        end
    end

    // State and output registers
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            idle_q        <= '0;
            digits_q      <= '{default: '0};
            value_q       <= '0;
            original_q    <= '0;
            complement_q  <= 1'b0;
            ambig_q       <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idle_q        <= idle_d;
            digits_q      <= digits_d;
            value_q       <= value_d;
            original_q    <= original_d;
            complement_q  <= complement_d;
            ambig_q       <= ambig_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign bus.value       = value_q;
    assign bus.original    = original_q;
    assign bus.complement  = complement_q;
    assign bus.ambig       = ambig_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_err   = frame_err_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: vector table, corner sequences, random frames vs a model.
module tb_seg7_capture;

    localparam int TO = 16;

    localparam logic [6:0] BL = 7'h7F;
    localparam logic [6:0] P0 = 7'h40, P1 = 7'h79, P2 = 7'h24, P3 = 7'h30, P4 = 7'h19;
    localparam logic [6:0] P5 = 7'h12, P8 = 7'h00, PA = 7'h08, PB = 7'h03, PF = 7'h0E;
    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef logic [5:0][6:0] frame_t;
    typedef struct {
        frame_t     p;
        bit         ok;
        logic [9:0] v;
        logic [9:0] o;
        bit         c;
        bit         a;
    } vec_t;

    logic CLOCK_50 = 1'b0;
    logic RESET    = 1'b1;
    always #5 CLOCK_50 = ~CLOCK_50;

    seg7_capture_if bus ();

    seg7_capture #(.FRAME_TIMEOUT(TO)) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .bus      (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int seen_valid = 0;
    int seen_err = 0;
    vec_t vecs[$];

    // Last good frame as the bench expects it to be displayed
    logic [9:0] h_v = '0, h_o = '0;
    bit h_c = 1'b0, h_a = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
        if (bus.frame_valid) seen_valid++;
        if (bus.frame_err) seen_err++;
    endtask

    task automatic send_digit(input logic [6:0] pat, input bit first);
        bus.seg_in    = pat;
        bus.seg_valid = 1'b1;
        bus.seg_first = first;
        tick();
        bus.seg_valid = 1'b0;
        bus.seg_first = 1'b0;
    endtask

    task automatic send_frame(input frame_t p);
        for (int i = 0; i < 6; i++) send_digit(p[i], i == 0);
    endtask

    function automatic frame_t fr(input logic [6:0] d0, d1, d2, d3, d4, d5);
        frame_t f;
        f[0] = d0; f[1] = d1; f[2] = d2; f[3] = d3; f[4] = d4; f[5] = d5;
        return f;
    endfunction

    task automatic add(input frame_t p, input bit ok, input logic [9:0] v, input logic [9:0] o,
                       input bit c, input bit a);
        vec_t e;
        e.p = p; e.ok = ok; e.v = v; e.o = o; e.c = c; e.a = a;
        vecs.push_back(e);
    endtask

    task automatic check_outputs(input string name);
        check({name, "_value"}, int'(bus.value), int'(h_v));
        check({name, "_original"}, int'(bus.original), int'(h_o));
        check({name, "_complement"}, int'(bus.complement), int'(h_c));
        check({name, "_ambig"}, int'(bus.ambig), int'(h_a));
    endtask

    // Frame, then one cycle later the pulse and data, then pulse gone
    task automatic apply(input string name, input frame_t p, input bit ok, input logic [9:0] v,
                         input logic [9:0] o, input bit c, input bit a);
        send_frame(p);
        tick();
        check({name, "_frame_valid"}, int'(bus.frame_valid), int'(ok));
        check({name, "_frame_err"}, int'(bus.frame_err), int'(!ok));
        if (ok) begin
            h_v = v; h_o = o; h_c = c; h_a = a;
        end
        check_outputs(name);
        tick();
        check({name, "_pulse_end"}, int'(bus.frame_valid | bus.frame_err), 0);
    endtask

    // 0..15 hex digit, 16 blank, -1 not a display pattern
    function automatic int dec(input logic [6:0] p);
        if (p == BL) return 16;
        for (int i = 0; i < 16; i++) if (p == HEX[i]) return i;
        return -1;
    endfunction

    function automatic void model(input frame_t p, output bit ok, output logic [9:0] v,
                                  output logic [9:0] o, output bit c, output bit a);
        int d[6];
        int dig2;
        int val;
        for (int i = 0; i < 6; i++) d[i] = dec(p[i]);
        ok = 1'b1; c = 1'b0; a = 1'b0; v = '0; o = '0; dig2 = 0;
        for (int i = 0; i < 6; i++) if (d[i] < 0) ok = 1'b0;
        if (d[4] != d[3] || d[5] != d[3]) ok = 1'b0;
        if (d[3] == 15) c = 1'b1;
        else if (d[3] != 16) ok = 1'b0;
        if (!c) begin
            for (int i = 0; i < 3; i++) if (d[i] == 16) ok = 1'b0;
            if (d[2] > 3) ok = 1'b0;
            dig2 = d[2];
        end else begin
            for (int i = 0; i < 3; i++) if (d[i] == 0 || d[i] == 16) ok = 1'b0;
            if (d[2] == 15) dig2 = 0;
            else if (d[2] > 3) ok = 1'b0;
            else dig2 = d[2];
            a = (d[0] == 15) || (d[1] == 15);
        end
        if (ok) begin
            val = dig2 * 256 + d[1] * 16 + d[0];
            v = 10'(val);
            o = c ? 10'((1024 - val) % 1024) : 10'(val);
        end else begin
            a = 1'b0;
            c = 1'b0;
        end
    endfunction

    function automatic logic [6:0] rnd_digit();
        int r;
        r = int'($urandom_range(0, 19));
        if (r < 16) return HEX[r];
        if (r < 18) return BL;
        if (r == 18) return PF;
        return 7'($urandom);
    endfunction

    initial begin
        bit ok, c, a;
        logic [9:0] v, o;
        frame_t p;
        int err_at, err_len;

        bus.seg_in = BL;
        bus.seg_valid = 1'b0;
        bus.seg_first = 1'b0;

        add(fr(P5, PA, P2, BL, BL, BL), 1, 10'h2A5, 10'h2A5, 0, 0);
        add(fr(PF, PF, P3, PF, PF, PF), 1, 10'h3FF, 10'h001, 1, 1);
        add(fr(PB, P2, PF, PF, PF, PF), 1, 10'h02B, 10'h3D5, 1, 0);
        add(fr(P5, PA, P2, BL, PF, BL), 0, 0, 0, 0, 0);
        add(fr(P5, 7'h55, P2, BL, BL, BL), 0, 0, 0, 0, 0);
        add(fr(P0, P0, P4, BL, BL, BL), 0, 0, 0, 0, 0);
        add(fr(P0, P1, P1, PF, PF, PF), 0, 0, 0, 0, 0);
        add(fr(P0, P0, P0, BL, BL, BL), 1, 10'h000, 10'h000, 0, 0);
        add(fr(PF, PF, PF, PF, PF, PF), 1, 10'h0FF, 10'h301, 1, 1);
        add(fr(P1, BL, P1, BL, BL, BL), 0, 0, 0, 0, 0);
        add(fr(P1, P1, P4, PF, PF, PF), 0, 0, 0, 0, 0);
        add(fr(P1, P2, P3, P8, P8, P8), 0, 0, 0, 0, 0);
        add(fr(P3, P2, P1, BL, BL, BL), 1, 10'h123, 10'h123, 0, 0);
        add(fr(P1, P2, P1, PF, PF, PF), 1, 10'h121, 10'h2DF, 1, 0);

        // Reset state
        #12;
        check("reset_pulses", int'(bus.frame_valid | bus.frame_err), 0);
        check_outputs("reset");
        RESET = 1'b0;
        tick();

        foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i].p, vecs[i].ok, vecs[i].v,
                                vecs[i].o, vecs[i].c, vecs[i].a);

        // Timeout after three digits
        send_digit(P1, 1); send_digit(P2, 0); send_digit(P3, 0);
        err_at = -1; err_len = 0; seen_valid = 0;
        for (int n = 1; n <= TO + 3; n++) begin
            tick();
            if (bus.frame_err) begin
                err_len++;
                if (err_at < 0) err_at = n;
            end
        end
        check("timeout_cycle", err_at, TO);
        check("timeout_len", err_len, 1);
        check("timeout_no_valid", seen_valid, 0);
        check_outputs("timeout_hold");

        // Restart after four digits, then a good frame: only the second reports
        seen_valid = 0; seen_err = 0;
        send_digit(P5, 1); send_digit(P5, 0); send_digit(P1, 0); send_digit(BL, 0);
        send_frame(fr(P4, P3, P2, BL, BL, BL));
        tick(); tick();
        check("restart_valid_count", seen_valid, 1);
        check("restart_err_count", seen_err, 0);
        h_v = 10'h234; h_o = 10'h234; h_c = 0; h_a = 0;
        check_outputs("restart");

        // Back-to-back: next frame starts in the resolve cycle
        send_frame(fr(P5, PA, P2, BL, BL, BL));
        send_digit(PF, 1);
        check("b2b_first_valid", int'(bus.frame_valid), 1);
        h_v = 10'h2A5; h_o = 10'h2A5; h_c = 0; h_a = 0;
        check_outputs("b2b_first");
        for (int i = 1; i < 6; i++) send_digit((i == 2) ? P3 : PF, 0);
        tick();
        check("b2b_second_valid", int'(bus.frame_valid), 1);
        h_v = 10'h3FF; h_o = 10'h001; h_c = 1; h_a = 1;
        check_outputs("b2b_second");
        tick();

        // Reset mid-frame: asynchronous clear, no pulse, rest of frame ignored
        send_digit(P1, 1); send_digit(P1, 0); send_digit(P1, 0);
        #2 RESET = 1'b1;
        #1;
        h_v = '0; h_o = '0; h_c = 0; h_a = 0;
        check_outputs("async_reset");
        #3 RESET = 1'b0;
        seen_valid = 0; seen_err = 0;
        send_digit(BL, 0); send_digit(BL, 0); send_digit(BL, 0);
        tick(); tick();
        check("reset_no_pulse", seen_valid + seen_err, 0);
        check_outputs("reset_after");

        // Random frames against the model
        for (int t = 0; t < 300; t++) begin
            int m;
            for (int i = 0; i < 3; i++) p[i] = rnd_digit();
            m = int'($urandom_range(0, 9));
            for (int i = 3; i < 6; i++) p[i] = (m < 5) ? BL : (m < 9) ? PF : rnd_digit();
            model(p, ok, v, o, c, a);
            apply($sformatf("rnd%0d", t), p, ok, v, o, c, a);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
